mant_btn_debounce: RTL
======================

# mant_btn_debounce

Front-end conditioning stage for the maintenance-mode controller. It takes the raw, asynchronous maintenance switch from the board, synchronizes and debounces it, and drives the clean level `m` straight into the maintenance FSM's `m` input. It also provides a one-cycle press pulse and a saturating glitch counter for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a press or a release; legal range ≥ 2.
- `GLITCH_W`, default 8: width of the rejected-glitch counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; low forces every register to its reset value.
- `btn_raw`  in  1  raw maintenance switch, asynchronous to `clk`, may bounce.
- `m`  out  1  debounced switch level; feeds the maintenance FSM `m` input.
- `m_pulse`  out  1  one-cycle strobe on accepted press.
- `glitch_cnt`  out  GLITCH_W  count of rejected transitions, saturating.
- `busy`  out  1  high while a transition is being qualified (ARMING or RELEASING).

## Operation
- Two-flop synchronizer on `btn_raw` produces `s`; no logic reads `btn_raw` directly.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`, cleared on every state entry.
- States (all registered; outputs decoded from state):
  - IDLE: `m`=0. If `s`=1, go to ARMING.
  - ARMING: `m`=0, `busy`=1.
    - If `s`=0, go to IDLE and increment `glitch_cnt`.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to ACTIVE.
    - Else `cnt`++.
  - ACTIVE: `m`=1. If `s`=0, go to RELEASING.
  - RELEASING: `m`=1, `busy`=1.
    - If `s`=1, go to ACTIVE and increment `glitch_cnt`.
    - Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else `cnt`++.
- `m_pulse`=1 for exactly the first cycle in ACTIVE entered from ARMING. A return from RELEASING does not pulse.
- `glitch_cnt` saturates at all-ones and never wraps. The only way to clear it is reset.
- Reset values: state IDLE, both sync flops 0, `cnt`=0, `m`=0, `m_pulse`=0, `busy`=0, `glitch_cnt`=0.
- Reset mid-qualification or while ACTIVE: `m` drops immediately (asynchronous). After release, a held switch is re-qualified from IDLE with the full latency.

## Timing
- Edge numbering: E1 is the first rising edge that samples `btn_raw`=1.
- Press path: sync1=1 at E1, `s`=1 at E2, ARMING at E3, ACTIVE at E(3+DEBOUNCE_CYCLES).
  - `m` and `m_pulse` rise after that edge.
  - Default press latency is 7 edges.
- Release path is symmetric: `m` falls after edge 3+DEBOUNCE_CYCLES, counted from the first edge sampling `btn_raw`=0.
- Rejection rules:
  - Any bounce shorter than DEBOUNCE_CYCLES stable samples is rejected with no change on `m`.
  - Each rejection adds exactly 1 to `glitch_cnt`.
- `m` is glitch-free and registered, so the downstream FSM may sample it directly on the same `clk`.
- Reset deassertion is synchronous to `clk` by board convention; no internal reset synchronizer.

## Structure
- Shared package `mant_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} deb_state_t`
  - default constant `MANT_DEBOUNCE_CYCLES`
- Sub-module `sync_2ff` (1-bit two-flop synchronizer, `clk`/`rst` active-low async).
  - Instantiated once here.
  - Reusable for other board inputs.
- Remaining logic is one state register, `cnt`, and `glitch_cnt`, all in the top module.

## Test plan
- Clean press: `rst` low 10 cycles, then high; `btn_raw` 0→1 and held. `m` rises after edge 7 (D=4), `m_pulse` high exactly 1 cycle, `glitch_cnt`=0.
- Bounce reject: `btn_raw` high for 2 cycles, low, high for 3 cycles, low. `m` stays 0, `glitch_cnt`=2, state returns to IDLE.
- Release with bounce: from ACTIVE, `btn_raw` low 2 cycles, high, then low and held. `glitch_cnt` +1, `m` stays 1 until edge 7 after the final fall, no `m_pulse`.
- Saturation: GLITCH_W=2 with 5 rejected glitches. `glitch_cnt`=3, no wrap.
- Reset mid-operation: assert `rst` low while ARMING (`cnt`=2), then while ACTIVE. All outputs go to 0 immediately. A held `btn_raw` re-qualifies with the full 7-edge latency after release.
- Chained with the maintenance FSM: `btn_raw` pulse of 20 time units. `enable_mant` responds to `m` exactly as when the FSM is driven directly, delayed by the debounce latency.

Source files
------------

// File: rtl/mant_pkg.sv
// mant_pkg: shared types and defaults for the maintenance-mode front end
package mant_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} deb_state_t;
  localparam int MANT_DEBOUNCE_CYCLES = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for asynchronous board inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops; rst is active-low and asynchronous
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/mant_btn_debounce.sv
// mant_btn_debounce: synchronize and debounce the maintenance switch into a clean level m
module mant_btn_debounce
  import mant_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MANT_DEBOUNCE_CYCLES,
  parameter int GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_raw,
  output logic                m,
  output logic                m_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  deb_state_t state, state_d;
  logic [CW-1:0] cnt;
  logic s, glitch_hit;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(btn_raw), .q(s));
  // encoding puts m on bit 1 and busy on bit 0, so both come straight off flops
  assign m = state[1];
  assign busy = state[0];
  // next-state: qualify s against the accepted level, flag aborted qualifications
  always_comb begin
    state_d = state;
    glitch_hit = 1'b0;
    case (state)
      IDLE:      state_d = s ? ARMING : IDLE;
      ARMING:    begin
        glitch_hit = !s;
        state_d = !s ? IDLE : (cnt == CNT_MAX ? ACTIVE : ARMING);
      end
      ACTIVE:    state_d = s ? ACTIVE : RELEASING;
      RELEASING: begin
        glitch_hit = s;
        state_d = s ? ACTIVE : (cnt == CNT_MAX ? IDLE : RELEASING);
      end
      default:   state_d = IDLE;
    endcase
  end
  // state, qualification counter (cleared on entry), press strobe and saturating glitch count
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      m_pulse <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= (state_d != state) ? '0 : (busy ? cnt + CW'(1) : cnt);
      m_pulse <= (state == ARMING) && (state_d == ACTIVE);
      if (glitch_hit && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
endmodule
